// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: HMS clock time base, button debounce, mode FSM
// and single-cycle count enables for time/alarm counters.
module clock_mode_ctrl #(
  parameter int P_TICK_1HZ = 50000000,
  parameter int P_SAMPLE   = 500000,
  parameter int P_BLINK    = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_max,
  input  logic       i_min_max,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_alm_min_inc,
  output logic       o_alm_hour_inc,
  output logic [5:0] o_blank
);

  localparam int TW =
    (P_TICK_1HZ > 1) ? $clog2(P_TICK_1HZ) : 1;
  localparam int SW =
    (P_SAMPLE > 1) ? $clog2(P_SAMPLE) : 1;
  localparam int BW =
    (P_BLINK > 1) ? $clog2(P_BLINK) : 1;

  typedef enum logic [1:0] {
    M_CLOCK = 2'd0,
    M_SETUP = 2'd1,
    M_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  // time bases
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_smp_cnt;
  logic          w_tick_1hz;
  logic          w_tick_smp;

  assign w_tick_1hz =
    (r_tick_cnt == TW'(P_TICK_1HZ - 1));
  assign w_tick_smp =
    (r_smp_cnt == SW'(P_SAMPLE - 1));

  // 1 Hz counter: wraps to 0 after the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick_1hz) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // button sample-rate counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_cnt <= '0;
    end else if (w_tick_smp) begin
      r_smp_cnt <= '0;
    end else begin
      r_smp_cnt <= r_smp_cnt + SW'(1);
    end
  end

  // button conditioning, bit order {sw2, sw1, sw0}
  logic [2:0] w_sw_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_hist0;
  logic [2:0] r_hist1;
  logic [2:0] r_deb;
  logic [2:0] w_deb_nxt;
  logic [2:0] r_press;
  logic       w_p0;
  logic       w_p1;
  logic       w_p2;

  assign w_sw_raw = {i_sw2, i_sw1, i_sw0};

  // agreeing samples take over, disagreeing bits hold
  assign w_deb_nxt = (r_hist0 & r_hist1) |
                     (r_deb & (r_hist0 ^ r_hist1));

  assign w_p0 = r_press[0];
  assign w_p1 = r_press[1];
  assign w_p2 = r_press[2];

  // two-flop synchronizer, idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  // two-deep sample history on the sample tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist0 <= '1;
      r_hist1 <= '1;
    end else if (w_tick_smp) begin
      r_hist0 <= r_sync2;
      r_hist1 <= r_hist0;
    end
  end

  // debounced level and 1->0 press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb   <= '1;
      r_press <= '0;
    end else begin
      r_deb   <= w_deb_nxt;
      r_press <= r_deb & ~w_deb_nxt;
    end
  end

  // mode FSM and increment decode
  mode_t r_mode;
  mode_t w_mode_nxt;
  pos_t  r_pos;
  pos_t  w_pos_nxt;

  logic w_sec_nxt;
  logic w_min_nxt;
  logic w_hour_nxt;
  logic w_amin_nxt;
  logic w_ahour_nxt;

  // state register for mode and position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= M_CLOCK;
      r_pos  <= POS_SEC;
    end else begin
      r_mode <= w_mode_nxt;
      r_pos  <= w_pos_nxt;
    end
  end

  // next state and enables from pre-update mode/position
  always_comb begin
    w_mode_nxt  = r_mode;
    w_pos_nxt   = r_pos;
    w_sec_nxt   = 1'b0;
    w_min_nxt   = 1'b0;
    w_hour_nxt  = 1'b0;
    w_amin_nxt  = 1'b0;
    w_ahour_nxt = 1'b0;
    if (w_p0) begin
      case (r_mode)
        M_CLOCK: begin
          w_mode_nxt = M_SETUP;
          w_pos_nxt  = POS_SEC;
        end
        M_SETUP: begin
          w_mode_nxt = M_ALARM;
          w_pos_nxt  = POS_MIN;
        end
        default: begin
          w_mode_nxt = M_CLOCK;
          w_pos_nxt  = POS_SEC;
        end
      endcase
    end else begin
      case (r_mode)
        M_CLOCK: begin
          if (w_tick_1hz) begin
            w_sec_nxt  = 1'b1;
            w_min_nxt  = i_sec_max;
            w_hour_nxt = i_sec_max & i_min_max;
          end
        end
        M_SETUP: begin
          if (w_p2) begin
            case (r_pos)
              POS_SEC: w_sec_nxt  = 1'b1;
              POS_MIN: w_min_nxt  = 1'b1;
              default: w_hour_nxt = 1'b1;
            endcase
          end
          if (w_p1) begin
            case (r_pos)
              POS_SEC: w_pos_nxt = POS_MIN;
              POS_MIN: w_pos_nxt = POS_HOUR;
              default: w_pos_nxt = POS_SEC;
            endcase
          end
        end
        M_ALARM: begin
          if (w_tick_1hz) begin
            w_sec_nxt  = 1'b1;
            w_min_nxt  = i_sec_max;
            w_hour_nxt = i_sec_max & i_min_max;
          end
          if (w_p2) begin
            if (r_pos == POS_HOUR) begin
              w_ahour_nxt = 1'b1;
            end else begin
              w_amin_nxt = 1'b1;
            end
          end
          if (w_p1) begin
            if (r_pos == POS_HOUR) begin
              w_pos_nxt = POS_MIN;
            end else begin
              w_pos_nxt = POS_HOUR;
            end
          end
        end
        default: begin
          w_mode_nxt = M_CLOCK;
          w_pos_nxt  = POS_SEC;
        end
      endcase
    end
  end

  // blink phase: restarts ON at any mode/position change
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic          w_chg;
  logic          w_blink_wrap;
  logic [5:0]    w_blank_nxt;

  assign w_chg = (w_mode_nxt != r_mode) ||
                 (w_pos_nxt != r_pos);
  assign w_blink_wrap =
    (r_blink_cnt == BW'(P_BLINK - 1));
  assign w_phase_nxt = w_chg ? 1'b1 :
    (w_blink_wrap ? ~r_phase : r_phase);

  // blink counter and phase flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else begin
      if (w_chg || w_blink_wrap) begin
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
      r_phase <= w_phase_nxt;
    end
  end

  // blank mask tracks the state being entered
  always_comb begin
    w_blank_nxt = 6'b000000;
    if ((w_mode_nxt != M_CLOCK) && !w_phase_nxt) begin
      unique case (1'b1)
        (w_pos_nxt == POS_SEC):  w_blank_nxt = 6'b000011;
        (w_pos_nxt == POS_MIN):  w_blank_nxt = 6'b001100;
        (w_pos_nxt == POS_HOUR): w_blank_nxt = 6'b110000;
        default:                 w_blank_nxt = 6'b000000;
      endcase
    end
  end

  // registered outputs
  logic       r_sec_inc;
  logic       r_min_inc;
  logic       r_hour_inc;
  logic       r_amin_inc;
  logic       r_ahour_inc;
  logic [5:0] r_blank;

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_inc   <= 1'b0;
      r_min_inc   <= 1'b0;
      r_hour_inc  <= 1'b0;
      r_amin_inc  <= 1'b0;
      r_ahour_inc <= 1'b0;
      r_blank     <= 6'b000000;
    end else begin
      r_sec_inc   <= w_sec_nxt;
      r_min_inc   <= w_min_nxt;
      r_hour_inc  <= w_hour_nxt;
      r_amin_inc  <= w_amin_nxt;
      r_ahour_inc <= w_ahour_nxt;
      r_blank     <= w_blank_nxt;
    end
  end

  assign o_mode         = r_mode;
  assign o_position     = r_pos;
  assign o_sec_inc      = r_sec_inc;
  assign o_min_inc      = r_min_inc;
  assign o_hour_inc     = r_hour_inc;
  assign o_alm_min_inc  = r_amin_inc;
  assign o_alm_hour_inc = r_ahour_inc;
  assign o_blank        = r_blank;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: scenario tasks with a scoreboard of
// expected mode/position changes and button-driven enables.
module tb_clock_mode_ctrl;

  localparam int PT = 10;
  localparam int PS = 4;
  localparam int PB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sw0 = 1'b1;
  logic       i_sw1 = 1'b1;
  logic       i_sw2 = 1'b1;
  logic       i_sec_max = 1'b0;
  logic       i_min_max = 1'b0;
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic       o_alm_min_inc;
  logic       o_alm_hour_inc;
  logic [5:0] o_blank;

  always #5 clk = ~clk;

  clock_mode_ctrl #(
    .P_TICK_1HZ(PT),
    .P_SAMPLE(PS),
    .P_BLINK(PB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_sw0(i_sw0),
    .i_sw1(i_sw1),
    .i_sw2(i_sw2),
    .i_sec_max(i_sec_max),
    .i_min_max(i_min_max),
    .o_mode(o_mode),
    .o_position(o_position),
    .o_sec_inc(o_sec_inc),
    .o_min_inc(o_min_inc),
    .o_hour_inc(o_hour_inc),
    .o_alm_min_inc(o_alm_min_inc),
    .o_alm_hour_inc(o_alm_hour_inc),
    .o_blank(o_blank)
  );

  int checks = 0;
  int errors = 0;

  // clock edges since reset release
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int nstep = 0;
  int chg_step = 0;
  int n_sec = 0;
  int n_min = 0;
  int n_hour = 0;
  int n_amin = 0;
  int n_ahour = 0;
  logic [3:0] prev_mp = 4'h0;

  logic [3:0] exp_mq[$];
  logic [3:0] obs_mq[$];
  logic [4:0] exp_iq[$];
  logic [4:0] obs_iq[$];

  // advance one cycle and log what the DUT produced
  task automatic step();
    @(negedge clk);
    nstep++;
    n_sec   += int'(o_sec_inc);
    n_min   += int'(o_min_inc);
    n_hour  += int'(o_hour_inc);
    n_amin  += int'(o_alm_min_inc);
    n_ahour += int'(o_alm_hour_inc);
    if ({o_mode, o_position} !== prev_mp) begin
      prev_mp = {o_mode, o_position};
      obs_mq.push_back(prev_mp);
      chg_step = nstep;
    end
    if (o_mode == 2'd1 &&
        (o_sec_inc || o_min_inc || o_hour_inc))
      obs_iq.push_back({o_sec_inc, o_min_inc,
                        o_hour_inc, 2'b00});
    if (o_alm_min_inc || o_alm_hour_inc)
      obs_iq.push_back({3'b000, o_alm_min_inc,
                        o_alm_hour_inc});
  endtask

  // hold the masked buttons low, release, let it settle
  task automatic press(input logic [2:0] m,
                       input int hold);
    {i_sw2, i_sw1, i_sw0} = ~m;
    repeat (hold) step();
    {i_sw2, i_sw1, i_sw0} = 3'b111;
    repeat (15) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_mode, o_position} !== 4'h0) begin
      errors++;
      $display("FAIL reset_mode_pos: got %b want 0000",
               {o_mode, o_position});
    end
    checks++;
    if ({o_sec_inc, o_min_inc, o_hour_inc,
         o_alm_min_inc, o_alm_hour_inc} !== 5'b0) begin
      errors++;
      $display("FAIL reset_inc: got %b want 00000",
               {o_sec_inc, o_min_inc, o_hour_inc,
                o_alm_min_inc, o_alm_hour_inc});
    end
    checks++;
    if (o_blank !== 6'b0) begin
      errors++;
      $display("FAIL reset_blank: got %b want 0", o_blank);
    end
    rst_n = 1'b1;
    prev_mp = 4'h0;
    nstep = 0;
  endtask

  task automatic test_tick();
    logic want;
    for (int i = 0; i < 45; i++) begin
      step();
      want = (cyc % PT == 0);
      checks++;
      if ({o_sec_inc, o_min_inc, o_hour_inc} !==
          {want, 2'b00}) begin
        errors++;
        $display("FAIL tick cyc=%0d: got %b want %b", cyc,
                 {o_sec_inc, o_min_inc, o_hour_inc},
                 {want, 2'b00});
      end
    end
    checks++;
    if (o_mode !== 2'd0 || o_blank !== 6'b0) begin
      errors++;
      $display("FAIL tick_idle: mode %0d blank %b want 0 0",
               o_mode, o_blank);
    end
  endtask

  task automatic test_carry();
    logic [2:0] want;
    int guard;
    i_sec_max = 1'b1;
    i_min_max = 1'b1;
    guard = 0;
    while (cyc % PT != 5 && guard < 20) begin
      step();
      guard++;
    end
    for (int i = 0; i < 30; i++) begin
      step();
      want = (cyc % PT == 0) ? 3'b111 : 3'b000;
      checks++;
      if ({o_sec_inc, o_min_inc, o_hour_inc} !== want) begin
        errors++;
        $display("FAIL carry_hms cyc=%0d: got %b want %b",
                 cyc, {o_sec_inc, o_min_inc, o_hour_inc},
                 want);
      end
    end
    i_min_max = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      want = (cyc % PT == 0) ? 3'b110 : 3'b000;
      checks++;
      if ({o_sec_inc, o_min_inc, o_hour_inc} !== want) begin
        errors++;
        $display("FAIL carry_ms cyc=%0d: got %b want %b",
                 cyc, {o_sec_inc, o_min_inc, o_hour_inc},
                 want);
      end
    end
    i_sec_max = 1'b0;
  endtask

  task automatic test_setup();
    int s0, s1, s2, s3, s4, k;
    logic [5:0] want;
    logic [3:0] wm, gm;
    logic [4:0] wi, gi;
    exp_mq.push_back({2'd1, 2'd0});
    press(3'b001, 20);
    s0 = n_sec; s1 = n_min; s2 = n_hour;
    s3 = n_amin; s4 = n_ahour;
    for (int i = 0; i < 100; i++) begin
      step();
      k = nstep - chg_step;
      want = ((k / PB) % 2 == 1) ? 6'b000011 : 6'b0;
      checks++;
      if (o_blank !== want) begin
        errors++;
        $display("FAIL setup_blank_sec k=%0d: got %b want %b",
                 k, o_blank, want);
      end
    end
    checks++;
    if (n_sec != s0 || n_min != s1 || n_hour != s2 ||
        n_amin != s3 || n_ahour != s4) begin
      errors++;
      $display("FAIL setup_halt: got %0d enables want 0",
               n_sec + n_min + n_hour + n_amin + n_ahour
               - s0 - s1 - s2 - s3 - s4);
    end
    exp_mq.push_back({2'd1, 2'd1});
    press(3'b010, 20);
    exp_mq.push_back({2'd1, 2'd2});
    press(3'b010, 20);
    for (int i = 0; i < 20; i++) begin
      step();
      k = nstep - chg_step;
      want = ((k / PB) % 2 == 1) ? 6'b110000 : 6'b0;
      checks++;
      if (o_blank !== want) begin
        errors++;
        $display("FAIL setup_blank_hour k=%0d: got %b want %b",
                 k, o_blank, want);
      end
    end
    exp_iq.push_back(5'b00100);
    press(3'b100, 20);
    while (exp_mq.size() != 0) begin
      wm = exp_mq.pop_front();
      checks++;
      if (obs_mq.size() == 0) begin
        errors++;
        $display("FAIL setup_modepos: got none want %b", wm);
      end else begin
        gm = obs_mq.pop_front();
        if (gm !== wm) begin
          errors++;
          $display("FAIL setup_modepos: got %b want %b",
                   gm, wm);
        end
      end
    end
    checks++;
    if (obs_mq.size() != 0) begin
      errors++;
      $display("FAIL setup_modepos_extra: got %b want none",
               obs_mq[0]);
      obs_mq.delete();
    end
    while (exp_iq.size() != 0) begin
      wi = exp_iq.pop_front();
      checks++;
      if (obs_iq.size() == 0) begin
        errors++;
        $display("FAIL setup_inc: got none want %b", wi);
      end else begin
        gi = obs_iq.pop_front();
        if (gi !== wi) begin
          errors++;
          $display("FAIL setup_inc: got %b want %b", gi, wi);
        end
      end
    end
    checks++;
    if (obs_iq.size() != 0) begin
      errors++;
      $display("FAIL setup_inc_extra: got %b want none",
               obs_iq[0]);
      obs_iq.delete();
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] wm, gm;
    logic [4:0] wi, gi;
    exp_iq.push_back(5'b00100);
    exp_mq.push_back({2'd1, 2'd0});
    press(3'b110, 20);
    exp_mq.push_back({2'd2, 2'd1});
    press(3'b101, 20);
    while (exp_mq.size() != 0) begin
      wm = exp_mq.pop_front();
      checks++;
      if (obs_mq.size() == 0) begin
        errors++;
        $display("FAIL simul_modepos: got none want %b", wm);
      end else begin
        gm = obs_mq.pop_front();
        if (gm !== wm) begin
          errors++;
          $display("FAIL simul_modepos: got %b want %b",
                   gm, wm);
        end
      end
    end
    checks++;
    if (obs_mq.size() != 0) begin
      errors++;
      $display("FAIL simul_modepos_extra: got %b want none",
               obs_mq[0]);
      obs_mq.delete();
    end
    while (exp_iq.size() != 0) begin
      wi = exp_iq.pop_front();
      checks++;
      if (obs_iq.size() == 0) begin
        errors++;
        $display("FAIL simul_inc: got none want %b", wi);
      end else begin
        gi = obs_iq.pop_front();
        if (gi !== wi) begin
          errors++;
          $display("FAIL simul_inc: got %b want %b", gi, wi);
        end
      end
    end
    checks++;
    if (obs_iq.size() != 0) begin
      errors++;
      $display("FAIL simul_inc_extra: got %b want none",
               obs_iq[0]);
      obs_iq.delete();
    end
  endtask

  task automatic test_alarm();
    int s0;
    logic [3:0] wm, gm;
    logic [4:0] wi, gi;
    exp_mq.push_back({2'd0, 2'd0});
    press(3'b001, 20);
    i_sw0 = 1'b0;
    repeat (3) step();
    i_sw0 = 1'b1;
    repeat (30) step();
    exp_mq.push_back({2'd1, 2'd0});
    press(3'b001, 20);
    exp_mq.push_back({2'd2, 2'd1});
    press(3'b001, 20);
    exp_iq.push_back(5'b00010);
    press(3'b100, 20);
    s0 = n_sec;
    repeat (30) step();
    checks++;
    if (n_sec - s0 != 3) begin
      errors++;
      $display("FAIL alarm_sec_run: got %0d pulses want 3",
               n_sec - s0);
    end
    exp_mq.push_back({2'd2, 2'd2});
    press(3'b010, 20);
    exp_iq.push_back(5'b00001);
    press(3'b100, 20);
    while (exp_mq.size() != 0) begin
      wm = exp_mq.pop_front();
      checks++;
      if (obs_mq.size() == 0) begin
        errors++;
        $display("FAIL alarm_modepos: got none want %b", wm);
      end else begin
        gm = obs_mq.pop_front();
        if (gm !== wm) begin
          errors++;
          $display("FAIL alarm_modepos: got %b want %b",
                   gm, wm);
        end
      end
    end
    checks++;
    if (obs_mq.size() != 0) begin
      errors++;
      $display("FAIL alarm_modepos_extra: got %b want none",
               obs_mq[0]);
      obs_mq.delete();
    end
    while (exp_iq.size() != 0) begin
      wi = exp_iq.pop_front();
      checks++;
      if (obs_iq.size() == 0) begin
        errors++;
        $display("FAIL alarm_inc: got none want %b", wi);
      end else begin
        gi = obs_iq.pop_front();
        if (gi !== wi) begin
          errors++;
          $display("FAIL alarm_inc: got %b want %b", gi, wi);
        end
      end
    end
    checks++;
    if (obs_iq.size() != 0) begin
      errors++;
      $display("FAIL alarm_inc_extra: got %b want none",
               obs_iq[0]);
      obs_iq.delete();
    end
  endtask

  task automatic test_async_reset();
    int guard;
    checks++;
    if ({o_mode, o_position} !== 4'b1010) begin
      errors++;
      $display("FAIL pre_reset_state: got %b want 1010",
               {o_mode, o_position});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mode, o_position} !== 4'h0) begin
      errors++;
      $display("FAIL async_mode_pos: got %b want 0000",
               {o_mode, o_position});
    end
    checks++;
    if ({o_sec_inc, o_min_inc, o_hour_inc,
         o_alm_min_inc, o_alm_hour_inc} !== 5'b0 ||
        o_blank !== 6'b0) begin
      errors++;
      $display("FAIL async_outputs: got %b %b want 0 0",
               {o_sec_inc, o_min_inc, o_hour_inc,
                o_alm_min_inc, o_alm_hour_inc}, o_blank);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_mp = 4'h0;
    guard = 0;
    step();
    while (!o_sec_inc && guard < 20) begin
      step();
      guard++;
    end
    checks++;
    if (!o_sec_inc || cyc != PT) begin
      errors++;
      $display("FAIL post_reset_tick: got sec=%b at %0d want 1 at %0d",
               o_sec_inc, cyc, PT);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_carry();
    test_setup();
    test_simultaneous();
    test_alarm();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
# clock_mode_ctrl

Synchronous mode and increment controller for the HMS digital clock. It replaces gated-clock sequencing with single-cycle count enables. It generates the 1 Hz time base, debounces the three push buttons, and runs the CLOCK / SETUP / ALARM mode state machine with a setup position. It emits one-cycle increment enables to the hour/min/sec time counters and the alarm counters, plus a blink blanking mask for the six-digit display multiplexer.

## Interface
- P_TICK_1HZ, 50000000, clk cycles per 1 Hz tick
- P_SAMPLE, 500000, clk cycles per button sample tick (100 Hz)
- P_BLINK, 25000000, clk cycles per blink phase
- clk  input  1  system clock (50 MHz)
- rst_n  input  1  reset; asynchronous, active-low
- i_sw0  input  1  mode button, raw, active-low
- i_sw1  input  1  position button, raw, active-low
- i_sw2  input  1  increment button, raw, active-low
- i_sec_max  input  1  level: time seconds counter == 59
- i_min_max  input  1  level: time minutes counter == 59
- o_mode  output  2  0 CLOCK, 1 SETUP, 2 ALARM (3 unused)
- o_position  output  2  0 SEC, 1 MIN, 2 HOUR
- o_sec_inc / o_min_inc / o_hour_inc  output  1 each  one-cycle time counter enables
- o_alm_min_inc / o_alm_hour_inc  output  1 each  one-cycle alarm counter enables
- o_blank  output  6  digit blank mask: [5:4] hour, [3:2] min, [1:0] sec

## Operation
- Tick generators: free-running counters 0..P-1; internal tick = 1 clk when count == P-1, then wrap to 0. Applies to tick_1hz and tick_smp.
- Button conditioning, per switch: 2-FF synchronizer (reset 1). Sampled on tick_smp into a 2-deep history. Debounced level updates only when the two samples agree. A press pulse is 1 clk on a debounced 1->0 transition. Release produces nothing.
- Mode FSM, advanced on a sw0 press: CLOCK -> SETUP -> ALARM -> CLOCK.
  - Entering SETUP sets position SEC.
  - Entering ALARM sets position MIN.
  - Entering CLOCK sets position SEC.
- sw1 press advances the position:
  - SETUP: SEC->MIN->HOUR->SEC.
  - ALARM: MIN->HOUR->MIN.
  - CLOCK: ignored.
- Increments, all evaluated against the current (pre-update) mode/position:
  - CLOCK and ALARM, on tick_1hz:
    - o_sec_inc = 1
    - o_min_inc = i_sec_max
    - o_hour_inc = i_sec_max & i_min_max
  - SETUP: tick_1hz is ignored (time halts). A sw2 press pulses exactly one of sec/min/hour_inc, chosen by position. No carry.
  - ALARM: a sw2 press pulses o_alm_min_inc or o_alm_hour_inc by position.
  - CLOCK: sw2 is ignored.
- Simultaneous events:
  - sw0 and sw2 presses in the same cycle: the mode change wins and sw2 is discarded.
  - sw1 and sw2 in the same cycle: the increment targets the old position, then the position advances.
  - sw0 and sw1 in the same cycle: the mode change wins and the position takes its entry value.
  - tick_1hz and sw2 in ALARM: both enables are emitted in the same cycle.
- Blink: the phase flag toggles every P_BLINK cycles. Any mode or position change restarts the counter with the phase ON. In SETUP/ALARM with phase OFF, o_blank drives the selected pair's two bits to 1; otherwise o_blank = 0.

## Timing
- Reset values (asynchronous):
  - o_mode 0, o_position 0, all *_inc 0, o_blank 0.
  - Tick and blink counters 0, blink phase ON.
  - Synchronizers, sample history and debounced levels 1.
- All outputs are registered. Each *_inc is high for exactly one clk, 1 cycle after its cause (tick or press pulse).
- o_mode/o_position update 1 cycle after the press pulse. Enables never assert in the cycle where the mode changes because of sw0.
- i_sec_max and i_min_max are sampled in the tick_1hz cycle only.
- Press latency from a stable low input: 2 clk (sync) + 2 sample ticks (up to 2*P_SAMPLE) + 1 clk (pulse) + 1 clk (output).
- A low pulse shorter than P_SAMPLE produces no press. A button held low produces one press only.
- rst_n asserted mid-operation clears all state immediately, regardless of clk. After release, the first tick_1hz occurs P_TICK_1HZ cycles later.

## Test plan
- P_TICK_1HZ=10, P_SAMPLE=4, P_BLINK=8, i_sec_max=0 -> o_sec_inc is a 1-clk pulse every 10 clk; o_min_inc/o_hour_inc stay 0; o_mode=0, o_blank=0.
- CLOCK with i_sec_max=1 and i_min_max=1 held -> o_sec_inc, o_min_inc and o_hour_inc are all high in the same single cycle, every 10 clk.
- i_sw0 low for 20 clk then high -> exactly one transition, o_mode 0->1 with o_position=0. No *_inc for the next 100 clk. o_blank alternates 6'b000011/6'b000000 every 8 clk, starting with 0.
- SETUP: two sw1 presses -> o_position=2; one sw2 press -> a single o_hour_inc pulse with sec/min_inc at 0; o_blank toggles 6'b110000, with the phase restarted at each position change.
- i_sw0 low for 3 clk (shorter than P_SAMPLE) -> o_mode unchanged. Then press sw0 twice -> o_mode=2, o_position=1. sw2 press -> o_alm_min_inc pulse while o_sec_inc continues every 10 clk.
- In ALARM at o_position=2, drive rst_n low asynchronously -> o_mode=0, o_position=0, o_blank=0 and all enables 0 before the next clk edge.
